// File: rtl/core_boot_pkg.sv
// Shared types and defaults for the core boot sequencer.
package core_boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_RST_CORE,
    S_RUN,
    S_DONE
  } boot_state_t;

  localparam int unsigned DEF_WRITE_HOLD  = 4;
  localparam int unsigned DEF_RST_CYCLES  = 2;
  localparam int unsigned DEF_RUN_TIMEOUT = 40000;

  // Word counts need one bit more than the address so a full memory is expressible.
  function automatic int unsigned boot_cnt_width(input int unsigned addr_len);
    return addr_len + 1;
  endfunction

endpackage

// File: rtl/boot_hold_counter.sv
// Loadable down-counter with zero flag; times write holds, core reset and the watchdog.
module boot_hold_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/core_boot_sequencer.sv
// Loads a program into the core over its APB-style port, then resets and runs it.
// Optional run watchdog enabled by defining BOOT_WATCHDOG_EN.
module core_boot_sequencer
  import core_boot_pkg::*;
#(
  parameter int unsigned DATA_LENGTH    = 32,
  parameter int unsigned ADDRESS_LENGTH = 11,
  parameter int unsigned WRITE_HOLD     = DEF_WRITE_HOLD,
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned RUN_TIMEOUT    = DEF_RUN_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDRESS_LENGTH:0] prog_len,
  input  logic                    src_valid,
  input  logic [DATA_LENGTH-1:0]  src_data,
  output logic                    src_ready,
  output logic                    instruction_load_start,
  output logic [31:0]             addr_in,
  output logic [31:0]             data_in,
  output logic                    pselect,
  output logic                    pwrite,
  output logic                    pready,
  output logic                    core_select,
  output logic                    core_rst,
  input  logic                    run_complete,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic [ADDRESS_LENGTH:0] words_loaded
);

  localparam int unsigned CntW = boot_cnt_width(ADDRESS_LENGTH);

  boot_state_t     state_q;
  logic [CntW-1:0] len_q, words_q, words_d;
  logic [31:0]     addr_q, data_q;
  logic            src_ready_q, ils_q, psel_q, core_sel_q, core_rst_q;
  logic            hs, last_word;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic [31:0]     cnt_val;
`ifdef BOOT_WATCHDOG_EN
  logic            timeout_q;
`endif

  assign hs        = src_valid && src_ready_q;
  assign words_d   = words_q + CntW'(1);
  assign last_word = (words_d == len_q);

  // The counter is reloaded on the same edge that enters the phase it times.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    if (!abort) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start && (prog_len == '0)) begin
            cnt_load = 1'b1;
            cnt_val  = 32'(RST_CYCLES - 1);
          end
        end
        S_FETCH: begin
          if (hs) begin
            cnt_load = 1'b1;
            cnt_val  = 32'(WRITE_HOLD - 1);
          end
        end
        S_WRITE: begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (last_word) begin
            cnt_load = 1'b1;
            cnt_val  = 32'(RST_CYCLES - 1);
          end
        end
        S_RST_CORE: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = 32'(RUN_TIMEOUT - 1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
`ifdef BOOT_WATCHDOG_EN
        S_RUN:   cnt_dec = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  boot_hold_counter #(.WIDTH(32)) u_hold (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      words_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      src_ready_q <= 1'b0;
      ils_q       <= 1'b0;
      psel_q      <= 1'b0;
      core_sel_q  <= 1'b0;
      core_rst_q  <= 1'b1;
`ifdef BOOT_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else if (abort) begin
      state_q     <= S_IDLE;
      src_ready_q <= 1'b0;
      ils_q       <= 1'b0;
      psel_q      <= 1'b0;
      core_sel_q  <= 1'b0;
      core_rst_q  <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q   <= prog_len;
            words_q <= '0;
`ifdef BOOT_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
            if (prog_len == '0) begin
              state_q    <= S_RST_CORE;
              core_sel_q <= 1'b1;
              core_rst_q <= 1'b0;
            end else begin
              state_q     <= S_FETCH;
              ils_q       <= 1'b1;
              src_ready_q <= 1'b1;
              core_sel_q  <= 1'b0;
            end
          end
        end
        S_FETCH: begin
          if (hs) begin
            data_q      <= 32'(src_data);
            addr_q      <= 32'(words_q);
            src_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (cnt_zero) begin
            psel_q  <= 1'b0;
            words_q <= words_d;
            if (last_word) begin
              ils_q      <= 1'b0;
              core_sel_q <= 1'b1;
              core_rst_q <= 1'b0;
              state_q    <= S_RST_CORE;
            end else begin
              src_ready_q <= 1'b1;
              state_q     <= S_FETCH;
            end
          end
        end
        S_RST_CORE: begin
          if (cnt_zero) begin
            core_rst_q <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (run_complete) begin
            state_q <= S_DONE;
          end
`ifdef BOOT_WATCHDOG_EN
          else if (cnt_zero) begin
            timeout_q  <= 1'b1;
            core_sel_q <= 1'b0;
            state_q    <= S_DONE;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign src_ready              = src_ready_q;
  assign instruction_load_start = ils_q;
  assign addr_in                = addr_q;
  assign data_in                = data_q;
  assign pselect                = psel_q;
  assign pwrite                 = psel_q;
  assign pready                 = psel_q;
  assign core_select            = core_sel_q;
  assign core_rst               = core_rst_q;
  assign busy                   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done                   = (state_q == S_DONE);
  assign words_loaded           = words_q;
`ifdef BOOT_WATCHDOG_EN
  assign timeout                = timeout_q;
`else
  assign timeout                = 1'b0;
`endif

endmodule

// File: tb/tb_core_boot_sequencer.sv
// Scoreboard bench for core_boot_sequencer; honours BOOT_WATCHDOG_EN when defined.
module tb_core_boot_sequencer;

  localparam int unsigned WH = 4;
  localparam int unsigned RC = 2;
  localparam int unsigned RT = 100;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic        src_valid = 1'b0, run_complete = 1'b0;
  logic [11:0] prog_len = '0;
  logic [31:0] src_data = '0;
  logic        src_ready, instruction_load_start, pselect, pwrite, pready;
  logic        core_select, core_rst, busy, done, timeout;
  logic [31:0] addr_in, data_in;
  logic [11:0] words_loaded;

  int unsigned n_checks = 0, n_pass = 0, n_beats = 0;
  bit          ils_seen = 1'b0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic        prev_psel = 1'b0, prev_crst = 1'b1;
  int unsigned burst_len = 0, rst_len = 0;

  always #5 clk = ~clk;

  core_boot_sequencer #(
    .DATA_LENGTH    (32),
    .ADDRESS_LENGTH (11),
    .WRITE_HOLD     (WH),
    .RST_CYCLES     (RC),
    .RUN_TIMEOUT    (RT)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .abort                  (abort),
    .prog_len               (prog_len),
    .src_valid              (src_valid),
    .src_data               (src_data),
    .src_ready              (src_ready),
    .instruction_load_start (instruction_load_start),
    .addr_in                (addr_in),
    .data_in                (data_in),
    .pselect                (pselect),
    .pwrite                 (pwrite),
    .pready                 (pready),
    .core_select            (core_select),
    .core_rst               (core_rst),
    .run_complete           (run_complete),
    .busy                   (busy),
    .done                   (done),
    .timeout                (timeout),
    .words_loaded           (words_loaded)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Monitor: pops the expected write at each pselect burst and times bursts and core reset pulses.
  always @(negedge clk) begin
    if (!rst) begin
      prev_psel = 1'b0;
      prev_crst = 1'b1;
      burst_len = 0;
      rst_len   = 0;
    end else begin
      if (instruction_load_start) ils_seen = 1'b1;
      if (pselect && !prev_psel) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          chk("wr_expected", 32'(exp_q.size()), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", addr_in, mon_e.a);
          chk("wr_data", data_in, mon_e.d);
        end
        chk("wr_strobes", 32'({pwrite, pready}), 3);
      end
      if (pselect) burst_len++;
      else if (prev_psel) begin
        chk("burst_len", burst_len, WH);
        burst_len = 0;
      end
      if (!core_rst) rst_len++;
      else if (!prev_crst) begin
        chk("core_rst_len", rst_len, RC);
        chk("core_select_at_run", 32'(core_select), 1);
        rst_len = 0;
      end
      prev_psel = pselect;
      prev_crst = core_rst;
    end
  end

  task automatic do_start(input int unsigned n);
    start    = 1'b1;
    prog_len = 12'(n);
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned idx);
    bit ok = 1'b0;
    src_data  = w;
    src_valid = 1'b1;
    exp_q.push_back('{a: 32'(idx), d: w});
    for (int c = 0; c < 100; c++) begin
      if (src_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    src_valid = 1'b0;
    chk("src_accept", 32'(ok), 1);
  endtask

  task automatic wait_run();
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (busy && core_select && core_rst) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_run", 32'(ok), 1);
  endtask

  task automatic complete_run(input string tag);
    repeat (20) @(negedge clk);
    chk({tag, "_busy_in_run"}, 32'(busy), 1);
    chk({tag, "_not_done"}, 32'(done), 0);
    run_complete = 1'b1;
    @(negedge clk);
    run_complete = 1'b0;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_done_core_sel"}, 32'(core_select), 1);
    chk({tag, "_done_core_rst"}, 32'(core_rst), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_src_ready"}, 32'(src_ready), 0);
    chk({tag, "_ils"}, 32'(instruction_load_start), 0);
    chk({tag, "_addr_in"}, addr_in, 0);
    chk({tag, "_data_in"}, data_in, 0);
    chk({tag, "_psel"}, 32'({pselect, pwrite, pready}), 0);
    chk({tag, "_core_select"}, 32'(core_select), 0);
    chk({tag, "_core_rst"}, 32'(core_rst), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int unsigned b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b1;
    @(negedge clk);

    // Three-word program, source always valid
    do_start(3);
    send_word(32'h0050_0093, 0);
    send_word(32'h00A0_0113, 1);
    send_word(32'h0020_81B3, 2);
    wait_run();
    chk("p3_words_loaded", 32'(words_loaded), 3);
    complete_run("p3");

    // Two words with a 7-cycle source stall between them
    do_start(2);
    send_word(32'hCAFE_0001, 0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        chk("stall_psel", 32'(pselect), 0);
        chk("stall_src_ready", 32'(src_ready), 1);
        chk("stall_ils", 32'(instruction_load_start), 1);
      end
    end
    send_word(32'hCAFE_0002, 1);
    wait_run();
    chk("stall_words_loaded", 32'(words_loaded), 2);
    complete_run("stall");

    // Empty program goes straight to core reset
    ils_seen = 1'b0;
    b0 = n_beats;
    do_start(0);
    chk("p0_core_rst_low", 32'(core_rst), 0);
    chk("p0_core_sel", 32'(core_select), 1);
    wait_run();
    chk("p0_no_writes", n_beats - b0, 0);
    chk("p0_no_ils", 32'(ils_seen), 0);
    chk("p0_words_loaded", 32'(words_loaded), 0);
    complete_run("p0");

    // Abort while running, then a one-word reload
    do_start(2);
    send_word(32'h1234_5678, 0);
    send_word(32'h9ABC_DEF0, 1);
    wait_run();
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_core_sel", 32'(core_select), 0);
    chk("abort_core_rst", 32'(core_rst), 1);
    chk("abort_words_kept", 32'(words_loaded), 2);
    do_start(1);
    send_word(32'h0000_0513, 0);
    wait_run();
    chk("reload_words_loaded", 32'(words_loaded), 1);
    complete_run("reload");

    // Run with no completion: watchdog or indefinite wait
    do_start(0);
    wait_run();
    repeat (RT - 1) @(negedge clk);
    chk("wd_pre_done", 32'(done), 0);
    chk("wd_pre_busy", 32'(busy), 1);
    @(negedge clk);
`ifdef BOOT_WATCHDOG_EN
    chk("wd_done", 32'(done), 1);
    chk("wd_timeout", 32'(timeout), 1);
    chk("wd_core_sel", 32'(core_select), 0);
    chk("wd_busy", 32'(busy), 0);
    do_start(0);
    chk("wd_timeout_cleared", 32'(timeout), 0);
    wait_run();
`else
    chk("nowd_busy", 32'(busy), 1);
    chk("nowd_done", 32'(done), 0);
    chk("nowd_timeout", 32'(timeout), 0);
`endif
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Asynchronous reset in the middle of a write burst
    do_start(2);
    send_word(32'h1111_2222, 0);
    chk("mid_write_psel", 32'(pselect), 1);
    #2 rst = 1'b0;
    #1 check_reset_vals("async");
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 0);
    chk("exp_q_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
